// File: rtl/rv4028_bus_target_if.sv
// ----------------------------------------------------------------------------
// rv4028_bus_target_if
// Fabric-side request/response handshake of the RV4028 bus target.
//   req_valid / req_ready : request handshake (valid held until ready)
//   req_write, req_io     : request is a write / targets I/O space
//   req_addr, req_wdata   : latched core address and write data
//   req_be                : active-high byte enables ([0] = low byte)
//   resp_valid/resp_rdata : one-cycle read-data return
// Modports: master = bus target (issues requests), slave = fabric.
// ----------------------------------------------------------------------------
interface rv4028_bus_target_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_io;
  logic [31:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        resp_valid;
  logic [15:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_io, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_io, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/rv4028_bus_target.sv
// ----------------------------------------------------------------------------
// rv4028_bus_target
// Converts each Z80-style memory or I/O cycle from the RV4028 core into one
// valid/ready request on the on-chip fabric, stretches the core cycle with
// wait_n until the fabric completes, and returns read data to the core.
// A timeout guarantees every bus cycle terminates.
//
// Parameters:
//   TIMEOUT  cycles allowed in REQ+RESP before forced completion (>= 2)
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   addr, data_in     core address / write data
//   data_out, data_oe read data to the core and its tristate enable
//   rd_n, wr_n        active-low read / write strobes
//   wrm_n             active-low byte write mask ([0] = low byte)
//   mreq_n, iorq_n    active-low memory / I/O qualifiers
//   wait_n            registered active-low cycle stretch
//   err               one-cycle pulse on timeout or malformed cycle
//   fab               fabric request/response handshake (master side)
// ----------------------------------------------------------------------------
module rv4028_bus_target #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_oe,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [1:0]  wrm_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  output logic        wait_n,
  output logic        err,
  rv4028_bus_target_if.master fab
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt;
  logic            start, released, malformed, tmo;
  logic            latch_req, err_d, data_oe_d;
  logic [15:0]     data_out_d;

  assign start     = (!mreq_n || !iorq_n) && (!rd_n || !wr_n);
  assign released  = rd_n && wr_n;
  assign malformed = (!rd_n && !wr_n) || (!mreq_n && !iorq_n);
  // Counter saturates at TIMEOUT-1, so this stays true until the FSM leaves.
  assign tmo       = (cnt == CW'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state;
    latch_req  = 1'b0;
    err_d      = 1'b0;
    data_oe_d  = 1'b0;
    data_out_d = data_out;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          latch_req = 1'b1;
          err_d     = malformed;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        // A handshake that completes in the same cycle as a strobe release
        // still counts: the fabric has already taken the request.
        if (fab.req_ready) begin
          if (fab.req_write) state_d = S_DONE;
          else if (released) state_d = S_DRAIN;
          else               state_d = S_RESP;
        end else if (released) begin
          state_d = S_IDLE;
        end else if (tmo) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          if (!fab.req_write) begin
            data_out_d = 16'hFFFF;
            data_oe_d  = 1'b1;
          end
        end
      end
      S_RESP: begin
        // Abort wins over a coincident response: the core is no longer
        // reading, so the data must not be driven onto the bus.
        if (released) begin
          state_d = fab.resp_valid ? S_IDLE : S_DRAIN;
        end else if (fab.resp_valid) begin
          state_d    = S_DONE;
          data_out_d = fab.resp_rdata;
          data_oe_d  = 1'b1;
        end else if (tmo) begin
          state_d    = S_DONE;
          err_d      = 1'b1;
          data_out_d = 16'hFFFF;
          data_oe_d  = 1'b1;
        end
      end
      S_DRAIN: begin
        // Swallow the outstanding response so it cannot leak into the next cycle.
        if (fab.resp_valid) begin
          state_d = S_IDLE;
        end else if (tmo) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_DONE: begin
        if (released) state_d = S_IDLE;
        else          data_oe_d = data_oe;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All core- and fabric-facing outputs are registered from the next state,
  // giving the one-cycle start-to-request latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_n        <= 1'b1;
      err           <= 1'b0;
      data_oe       <= 1'b0;
      data_out      <= '0;
      fab.req_valid <= 1'b0;
      fab.req_write <= 1'b0;
      fab.req_io    <= 1'b0;
      fab.req_addr  <= '0;
      fab.req_wdata <= '0;
      fab.req_be    <= '0;
      cnt           <= '0;
    end else begin
      wait_n        <= !(state_d == S_REQ || state_d == S_RESP || state_d == S_DRAIN);
      err           <= err_d;
      data_oe       <= data_oe_d;
      data_out      <= data_out_d;
      fab.req_valid <= (state_d == S_REQ);
      if (latch_req) begin
        fab.req_write <= !wr_n;
        fab.req_io    <= mreq_n;   // memory wins when both qualifiers are low
        fab.req_addr  <= addr;
        fab.req_wdata <= data_in;
        fab.req_be    <= ~wrm_n;
      end
      if (state == S_IDLE) cnt <= '0;
      else if ((state == S_REQ || state == S_RESP || state == S_DRAIN) && !tmo)
        cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_rv4028_bus_target.sv
// ----------------------------------------------------------------------------
// tb_rv4028_bus_target
// Directed self-checking bench for rv4028_bus_target with TIMEOUT = 8.
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// too, so each check sees the registered result of the preceding edge.
// ----------------------------------------------------------------------------
module tb_rv4028_bus_target;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_oe;
  logic        rd_n, wr_n;
  logic [1:0]  wrm_n;
  logic        mreq_n, iorq_n;
  logic        wait_n;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  rv4028_bus_target_if fab ();

  rv4028_bus_target #(.TIMEOUT(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .data_oe  (data_oe),
    .rd_n     (rd_n),
    .wr_n     (wr_n),
    .wrm_n    (wrm_n),
    .mreq_n   (mreq_n),
    .iorq_n   (iorq_n),
    .wait_n   (wait_n),
    .err      (err),
    .fab      (fab)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    rd_n = 1'b1; wr_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; wrm_n = 2'b11;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    addr = '0; data_in = '0;
    bus_idle();
    fab.req_ready = 1'b0; fab.resp_valid = 1'b0; fab.resp_rdata = '0;
    tick(); tick();

    // Reset state
    check("rst wait_n",    wait_n, 1);
    check("rst data_oe",   data_oe, 0);
    check("rst data_out",  data_out, 0);
    check("rst req_valid", fab.req_valid, 0);
    check("rst req_addr",  fab.req_addr, 0);
    check("rst req_be",    fab.req_be, 0);
    check("rst err",       err, 0);
    rst = 1'b0;
    tick();

    // 1. Memory read 0x1000, ready=1, response 3 cycles after accept
    addr = 32'h0000_1000; mreq_n = 1'b0; rd_n = 1'b0; fab.req_ready = 1'b1;
    tick();
    check("rd req_valid", fab.req_valid, 1);
    check("rd req_addr",  fab.req_addr, 32'h0000_1000);
    check("rd req_write", fab.req_write, 0);
    check("rd req_io",    fab.req_io, 0);
    check("rd err",       err, 0);
    check("rd wait0",     wait_n, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("rd wait%0d", i), wait_n, 0);
      check($sformatf("rd oe%0d", i), data_oe, 0);
    end
    check("rd valid dropped", fab.req_valid, 0);
    fab.resp_valid = 1'b1; fab.resp_rdata = 16'hBEEF;
    tick();
    fab.resp_valid = 1'b0; fab.resp_rdata = 16'h0000;
    check("rd wait_n rel", wait_n, 1);
    check("rd data_out",   data_out, 16'hBEEF);
    check("rd data_oe",    data_oe, 1);
    tick();
    check("rd hold oe",   data_oe, 1);
    check("rd hold data", data_out, 16'hBEEF);
    bus_idle();
    tick();
    check("rd oe off", data_oe, 0);
    check("rd idle wait", wait_n, 1);

    // 2. I/O write 0x20, data 0x1234, wrm_n=10, ready delayed
    fab.req_ready = 1'b0;
    addr = 32'h20; data_in = 16'h1234; wrm_n = 2'b10; iorq_n = 1'b0; wr_n = 1'b0;
    tick();
    check("wr req_valid", fab.req_valid, 1);
    check("wr req_io",    fab.req_io, 1);
    check("wr req_write", fab.req_write, 1);
    check("wr req_be",    fab.req_be, 2'b01);
    check("wr err",       err, 0);
    addr = 32'hDEAD_0000; data_in = 16'hFFFF; wrm_n = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("wr stall valid%0d", i), fab.req_valid, 1);
      check($sformatf("wr stall addr%0d", i),  fab.req_addr, 32'h20);
      check($sformatf("wr stall wdata%0d", i), fab.req_wdata, 16'h1234);
      check($sformatf("wr stall be%0d", i),    fab.req_be, 2'b01);
      check($sformatf("wr stall wait%0d", i),  wait_n, 0);
    end
    fab.req_ready = 1'b1;
    tick();
    check("wr accepted wait_n", wait_n, 1);
    check("wr accepted valid",  fab.req_valid, 0);
    check("wr data_oe",         data_oe, 0);
    bus_idle();
    tick();
    check("wr idle wait", wait_n, 1);

    // 3. Read with no response -> timeout after 8 cycles of req_valid
    addr = 32'h0000_4000; mreq_n = 1'b0; rd_n = 1'b0;
    tick();
    check("to req_valid", fab.req_valid, 1);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check($sformatf("to wait%0d", i), wait_n, 0);
      check($sformatf("to err%0d", i), err, 0);
    end
    tick();
    check("to wait_n",   wait_n, 1);
    check("to err",      err, 1);
    check("to data_out", data_out, 16'hFFFF);
    check("to data_oe",  data_oe, 1);
    tick();
    check("to err pulse", err, 0);
    check("to oe hold",   data_oe, 1);
    bus_idle();
    tick();
    check("to oe off", data_oe, 0);

    // 4. Read aborted in RESP, late response drained
    addr = 32'h0000_2000; mreq_n = 1'b0; rd_n = 1'b0;
    tick();
    check("ab req_valid", fab.req_valid, 1);
    tick();
    check("ab resp wait", wait_n, 0);
    bus_idle();
    tick();
    check("ab drain wait", wait_n, 0);
    check("ab drain oe",   data_oe, 0);
    tick();
    check("ab drain wait2", wait_n, 0);
    fab.resp_valid = 1'b1; fab.resp_rdata = 16'h7777;
    tick();
    fab.resp_valid = 1'b0;
    check("ab idle wait", wait_n, 1);
    check("ab idle oe",   data_oe, 0);
    check("ab data kept", data_out, 16'hFFFF);
    check("ab err",       err, 0);
    addr = 32'h0000_3000; data_in = 16'h5555; wrm_n = 2'b00; mreq_n = 1'b0; wr_n = 1'b0;
    tick();
    check("ab next valid", fab.req_valid, 1);
    check("ab next be",    fab.req_be, 2'b11);
    check("ab next wdata", fab.req_wdata, 16'h5555);
    tick();
    check("ab next done", wait_n, 1);
    bus_idle();
    tick();

    // 5. All qualifiers and strobes low -> memory write with err
    fab.req_ready = 1'b0;
    addr = 32'h44; data_in = 16'hA5A5; wrm_n = 2'b00;
    mreq_n = 1'b0; iorq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
    tick();
    check("mf err",       err, 1);
    check("mf req_write", fab.req_write, 1);
    check("mf req_io",    fab.req_io, 0);
    check("mf req_valid", fab.req_valid, 1);
    tick();
    check("mf err pulse", err, 0);
    fab.req_ready = 1'b1;
    tick();
    check("mf done", wait_n, 1);
    bus_idle();
    tick();

    // 6. Write with all bytes masked still issued with be=00
    addr = 32'h50; data_in = 16'h0F0F; wrm_n = 2'b11; mreq_n = 1'b0; wr_n = 1'b0;
    tick();
    check("nb req_valid", fab.req_valid, 1);
    check("nb req_be",    fab.req_be, 2'b00);
    tick();
    bus_idle();
    tick();

    // 7. Reset in RESP, late response ignored
    addr = 32'h0000_6000; mreq_n = 1'b0; rd_n = 1'b0;
    tick();
    tick();
    check("rs resp wait", wait_n, 0);
    rst = 1'b1;
    tick();
    check("rs wait_n",    wait_n, 1);
    check("rs req_valid", fab.req_valid, 0);
    check("rs req_addr",  fab.req_addr, 0);
    check("rs req_write", fab.req_write, 0);
    check("rs req_io",    fab.req_io, 0);
    check("rs req_wdata", fab.req_wdata, 0);
    check("rs req_be",    fab.req_be, 0);
    check("rs data_out",  data_out, 0);
    check("rs data_oe",   data_oe, 0);
    check("rs err",       err, 0);
    rst = 1'b0;
    bus_idle();
    fab.resp_valid = 1'b1; fab.resp_rdata = 16'h1111;
    tick();
    fab.resp_valid = 1'b0;
    check("rs late wait",  wait_n, 1);
    check("rs late oe",    data_oe, 0);
    check("rs late data",  data_out, 0);
    check("rs late valid", fab.req_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rv4028_bus_target.md
# rv4028_bus_target

Bus target sitting directly downstream of the RV4028 femtorv core's external Z80-style bus (addr/data/rd_n/wr_n/wrm_n/mreq_n/iorq_n/wait_n). It detects each memory or I/O cycle and converts it into a single valid/ready request to the on-chip fabric. It stretches the core's cycle with `wait_n` until the fabric completes, and drives read data back onto the bus. A timeout counter guarantees every bus cycle terminates.

## Interface
- `TIMEOUT`, 64: cycles allowed in REQ+RESP before forced completion (≥2).
- `clk`  in  1  single clock; all bus inputs synchronous to it.
- `rst`  in  1  synchronous, active-high reset.
- `addr`  in  32  core address.
- `data_in`  in  16  core write data.
- `data_out`  out  16  read data to core.
- `data_oe`  out  1  drive enable for `data_out` (external tristate).
- `rd_n`, `wr_n`  in  1  active-low read/write strobes.
- `wrm_n`  in  2  active-low byte write mask ([0]=low byte).
- `mreq_n`, `iorq_n`  in  1  active-low memory / I/O cycle qualifiers.
- `wait_n`  out  1  active-low cycle stretch to core, registered.
- `req_valid`  out  1  fabric request valid.
- `req_ready`  in  1  fabric accepts request.
- `req_write`, `req_io`  out  1  request is write / I/O space.
- `req_addr`  out  32; `req_wdata`  out  16; `req_be`  out  2 (active-high, = ~wrm_n).
- `resp_valid`  in  1  read data valid (1-cycle pulse).
- `resp_rdata`  in  16  read data.
- `err`  out  1  one-cycle pulse on timeout or malformed cycle.

## Operation
- States: IDLE, REQ, RESP, DONE, DRAIN.
- Start = (!mreq_n | !iorq_n) & (!rd_n | !wr_n), sampled in IDLE. On start: latch addr, data_in, ~wrm_n, write=!wr_n, io=mreq_n (mreq wins if both low) → REQ.
- Both rd_n and wr_n low at start: treated as write; `err` pulses. Both mreq_n and iorq_n low: memory cycle, `err` pulses.
- Write with wrm_n=2'b11 is still issued, with req_be=00.
- REQ: req_valid=1, fields stable. On req_valid&req_ready: write → DONE; read → RESP.
- RESP: on resp_valid, capture resp_rdata into data_out, data_oe=1 → DONE. resp_valid outside RESP/DRAIN is ignored.
- DONE: wait_n=1. Hold data_oe/data_out while rd_n low. When rd_n & wr_n both high: data_oe=0 → IDLE.
- Timeout: counter clears on entry to REQ and increments each cycle in REQ/RESP. Reaching TIMEOUT-1 without completion: req_valid=0, data_out=16'hFFFF (reads only), data_oe=1 for reads, err pulse → DONE.
- Abort (rd_n & wr_n both high while in REQ/RESP): REQ not yet accepted → IDLE, req_valid dropped. RESP → DRAIN; DRAIN waits for resp_valid (data discarded) or timeout, then → IDLE.
- Reset values: wait_n=1, data_oe=0, data_out=0, req_valid=0, req_write=0, req_io=0, req_addr=0, req_wdata=0, req_be=0, err=0, state IDLE, counter 0. Reset mid-cycle abandons any outstanding request; a late resp_valid is ignored.

## Timing
- Cycle N: start sampled. N+1: req_valid=1, wait_n=0 (both registered).
- wait_n=0 in REQ, RESP, DRAIN; 1 in IDLE and DONE.
- Write, req_ready already high: accepted at N+1; DONE at N+2, wait_n=1 at N+2.
- Read: resp_valid at cycle M → data_out valid, data_oe=1, wait_n=1 at M+1.
- Strobe release seen at cycle K in DONE → data_oe=0 at K+1; a new start is detectable from K+1.
- The request holds all fields unchanged while req_valid & !req_ready.
- The counter never wraps; err is exactly one cycle.

## Test plan
- Memory read 0x0000_1000, req_ready=1, resp_valid 3 cycles after accept with 0xBEEF → wait_n low for 4 cycles, then data_out=0xBEEF, data_oe=1 until rd_n rises.
- I/O write 0x20, data 0x1234, wrm_n=2'b10, req_ready delayed 5 cycles → req_io=1, req_be=01, req_wdata=0x1234 held stable, wait_n released the cycle after accept.
- Read, req_ready=1, no response, TIMEOUT=8 → err pulse, data_out=0xFFFF, wait_n=1 at 8 cycles after req_valid.
- Read aborted in RESP, resp_valid arrives 2 cycles later → DRAIN, then IDLE; data_oe never asserts; next cycle serviced normally.
- mreq_n, iorq_n, rd_n, wr_n all low → err pulse, memory write issued.
- rst asserted in RESP → next cycle all outputs at reset values; later resp_valid ignored.
